// File: rtl/usb_fs_rx_phy_pkg.sv
// Shared types and constants for the full-speed USB receive front end.
//   line_state_t : decoded D+/D- pair (J, K, SE0, SE1)
//   rx_state_t   : receive FSM states
//   decode_line  : maps a synchronized {dp,dn} pair to a line state
package usb_fs_rx_phy_pkg;

  typedef enum logic [1:0] {J = 2'd0, K = 2'd1, SE0 = 2'd2, SE1 = 2'd3} line_state_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, EOP = 2'd3} rx_state_t;

  localparam int USB_CLKS_PER_BIT   = 4;
  localparam int USB_STUFF_LIMIT    = 6;
  localparam int USB_SYNC_MIN_ZEROS = 3;
  // Decoded 1s seen in SYNC before the accept point mean the line went back to J idle.
  localparam int USB_SYNC_IDLE_ONES = 3;

  function automatic line_state_t decode_line(input logic dp, input logic dn);
    case ({dp, dn})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_fs_rx_phy_if.sv
// Receive-side byte interface of the USB FS PHY.
//   rx_data   : received byte, stable while rx_valid=1
//   rx_valid  : one-cycle byte strobe
//   rx_active : high from SYNC accept until EOP or abort
//   rx_eop    : one-cycle clean end-of-packet strobe
//   rx_error  : one-cycle error strobe (stuff violation, SE1, bad residual)
// master = PHY (drives), slave = packet decoder (consumes).
interface usb_fs_rx_phy_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;

  modport master (output rx_data, rx_valid, rx_active, rx_eop, rx_error);
  modport slave  (input  rx_data, rx_valid, rx_active, rx_eop, rx_error);
endinterface

// File: rtl/usb_fs_rx_phy_dpll.sv
// Line conditioning and bit-clock recovery for the USB FS receiver.
//   clk48, rst_n : 48 MHz clock, async active-low reset
//   dp_i, dn_i   : raw pads, asynchronous to clk48
//   line_state   : registered, synchronized line state
//   sample_en    : one-cycle strobe marking the mid-bit sample of line_state
module usb_fs_rx_phy_dpll
  import usb_fs_rx_phy_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = 2
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        dp_i,
  input  logic        dn_i,
  output line_state_t line_state,
  output logic        sample_en
);

  localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [1:0]    dp_sync, dn_sync;
  line_state_t   ls_now, ls_q;
  logic [PW-1:0] phase;
  logic          jk_edge;

  // Synchronizers reset to the J pattern so the line history starts idle.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      dp_sync <= 2'b11;
      dn_sync <= 2'b00;
    end else begin
      dp_sync <= {dp_sync[0], dp_i};
      dn_sync <= {dn_sync[0], dn_i};
    end
  end

  assign ls_now = decode_line(dp_sync[1], dn_sync[1]);

  // Only J/K transitions carry timing; SE0 entry is not used to realign.
  assign jk_edge = (ls_now != ls_q) && ((ls_now == J) || (ls_now == K));

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      ls_q  <= J;
      phase <= '0;
    end else begin
      ls_q <= ls_now;
      if (jk_edge || (phase == PW'(CLKS_PER_BIT - 1))) phase <= '0;
      else                                            phase <= phase + 1'b1;
    end
  end

  // Sampling the registered copy keeps a bit that is one clock short still
  // inside its own cell at the sample point.
  assign line_state = ls_q;
  assign sample_en  = (phase == PW'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_fs_rx_phy.sv
// USB full-speed receive front end: clock recovery, NRZI decode, SYNC
// detection, bit unstuffing, byte assembly and EOP detection.
//   clk48, rst_n : 48 MHz clock, async active-low reset
//   dp_i, dn_i   : raw D+/D- pads
//   rx           : byte/strobe interface (master side)
module usb_fs_rx_phy
  import usb_fs_rx_phy_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = 2,
  parameter int STUFF_LIMIT  = USB_STUFF_LIMIT
) (
  input  logic            clk48,
  input  logic            rst_n,
  input  logic            dp_i,
  input  logic            dn_i,
  usb_fs_rx_phy_if.master rx
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SYNC = SYNC;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_EOP  = EOP;

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int ZW = $clog2(USB_SYNC_MIN_ZEROS + 1);

  line_state_t   line_state, prev_ls;
  logic          sample_en;
  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [OW-1:0] ones_cnt;
  logic [ZW-1:0] zero_cnt;
  logic          nrzi_bit;

  logic [7:0] data_q;
  logic       valid_q, active_q, eop_q, error_q;

  usb_fs_rx_phy_dpll #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_dpll (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .dp_i       (dp_i),
    .dn_i       (dn_i),
    .line_state (line_state),
    .sample_en  (sample_en)
  );

  // NRZI: no change since the previous sample is a 1.
  assign nrzi_bit = (line_state == prev_ls);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      prev_ls  <= J;
      shreg    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      zero_cnt <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      eop_q    <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      error_q <= 1'b0;
      if (sample_en) begin
        prev_ls <= line_state;
        case (state)
          ST_IDLE: begin
            if (line_state == K) begin
              state    <= ST_SYNC;
              zero_cnt <= ZW'(1);   // the J->K step is the first SYNC zero
              ones_cnt <= '0;
            end
          end
          ST_SYNC: begin
            if ((line_state == SE0) || (line_state == SE1)) begin
              state <= ST_IDLE;
            end else if (!nrzi_bit) begin
              if (zero_cnt != ZW'(USB_SYNC_MIN_ZEROS)) zero_cnt <= zero_cnt + 1'b1;
              ones_cnt <= '0;
            end else if (zero_cnt == ZW'(USB_SYNC_MIN_ZEROS)) begin
              state    <= ST_DATA;
              active_q <= 1'b1;
              bit_cnt  <= '0;
              ones_cnt <= '0;
            end else if (ones_cnt == OW'(USB_SYNC_IDLE_ONES - 1)) begin
              state <= ST_IDLE;
            end else begin
              zero_cnt <= '0;
              ones_cnt <= ones_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (line_state == SE0) begin
              state <= ST_EOP;
            end else if (line_state == SE1) begin
              error_q  <= 1'b1;
              active_q <= 1'b0;
              state    <= ST_IDLE;
            end else if (ones_cnt == OW'(STUFF_LIMIT)) begin
              // This bit must be the stuffed 0; it is dropped, never shifted.
              if (nrzi_bit) begin
                error_q  <= 1'b1;
                active_q <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                ones_cnt <= '0;
              end
            end else begin
              shreg    <= {nrzi_bit, shreg[7:1]};
              ones_cnt <= nrzi_bit ? ones_cnt + 1'b1 : '0;
              bit_cnt  <= bit_cnt + 1'b1;   // wraps to 0 at each byte
              if (bit_cnt == 3'd7) begin
                data_q  <= {nrzi_bit, shreg[7:1]};
                valid_q <= 1'b1;
              end
            end
          end
          ST_EOP: begin
            if (line_state == J) begin
              // Up to one dribble bit is normal; anything more is a truncated byte.
              if (bit_cnt <= 3'd1) eop_q   <= 1'b1;
              else                 error_q <= 1'b1;
              active_q <= 1'b0;
              state    <= ST_IDLE;
            end else if (line_state != SE0) begin
              error_q  <= 1'b1;
              active_q <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_active = active_q;
  assign rx.rx_eop    = eop_q;
  assign rx.rx_error  = error_q;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Self-checking bench for usb_fs_rx_phy. Packets are built from bytes by an
// encoder (SYNC, bit stuffing, NRZI, EOP) and played onto dp/dn; a monitor
// logs strobes and the directed sequence compares them to expectations.
module tb_usb_fs_rx_phy;

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic clk48 = 1'b0, rst_n = 1'b0, dp_i = 1'b1, dn_i = 1'b0;
  int   cyc = 0;
  int   tests = 0, fails = 0;

  usb_fs_rx_phy_if rx_if ();

  usb_fs_rx_phy dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .dp_i  (dp_i),
    .dn_i  (dn_i),
    .rx    (rx_if)
  );

  always #10 clk48 = ~clk48;
  always @(posedge clk48) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [7:0] got[$];
  int n_eop = 0, n_err = 0, n_both = 0, n_val_inact = 0;
  int err_cyc = 0, eop_cyc = 0, valid_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic act_d = 1'b0;

  always @(negedge clk48) begin
    if (rx_if.rx_valid) begin
      got.push_back(rx_if.rx_data);
      valid_cyc = cyc;
      if (!rx_if.rx_active) n_val_inact++;
    end
    if (rx_if.rx_eop)   begin n_eop++; eop_cyc = cyc; end
    if (rx_if.rx_error) begin n_err++; err_cyc = cyc; end
    if (rx_if.rx_valid && rx_if.rx_eop) n_both++;
    if (rx_if.rx_active && !act_d) rise_cyc = cyc;
    if (!rx_if.rx_active && act_d) fall_cyc = cyc;
    act_d = rx_if.rx_active;
  end

  task automatic clr();
    got.delete();
    n_eop = 0; n_err = 0; n_both = 0; n_val_inact = 0;
    err_cyc = 0; eop_cyc = 0; valid_cyc = 0; rise_cyc = 0; fall_cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
    chk({tag, " count"}, got.size(), exp.size());
    foreach (exp[i]) chk({tag, " byte"}, (i < got.size()) ? {24'h0, got[i]} : 32'hffff_ffff, {24'h0, exp[i]});
  endtask

  // ---------------- encoder ----------------
  logic [1:0] cl[$];   // level per cell
  int         cw[$];   // width in clk48 cycles
  int         cs[$];   // cycle at which the cell was driven
  logic [1:0] lvl;
  bit         jit_on, jit_short;
  int         ones;

  task automatic put(input logic [1:0] l, input int w);
    cl.push_back(l); cw.push_back(w);
  endtask

  // One NRZI bit on the wire; with jitter, cell widths alternate 5/3 clocks.
  task automatic nrzi(input bit b);
    int w;
    if (!b) lvl = (lvl == LJ) ? LK : LJ;
    w = 4;
    if (jit_on) begin w = jit_short ? 3 : 5; jit_short = !jit_short; end
    put(lvl, w);
  endtask

  task automatic data_bit(input bit b);
    nrzi(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin nrzi(1'b0); ones = 0; end
  endtask

  task automatic start_pkt(input bit jitter);
    cl.delete(); cw.delete(); cs.delete();
    lvl = LJ; jit_on = 1'b0; jit_short = 1'b0; ones = 0;
    put(LJ, 16);
    jit_on = jitter;
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
  endtask

  task automatic end_pkt();
    jit_on = 1'b0;
    put(LSE0, 8); put(LJ, 4); put(LJ, 16);
  endtask

  task automatic build(input logic [7:0] bytes[$], input int nextra, input bit jitter);
    start_pkt(jitter);
    foreach (bytes[i]) for (int b = 0; b < 8; b++) data_bit(bytes[i][b]);
    for (int e = 0; e < nextra; e++) data_bit(1'($urandom_range(1)));
    end_pkt();
  endtask

  task automatic play();
    for (int i = 0; i < cl.size(); i++) begin
      cs.push_back(cyc);
      {dp_i, dn_i} = cl[i];
      repeat (cw[i]) @(negedge clk48);
    end
  endtask

  // Run one packet and compare against the rules: bytes in order, then
  // rx_eop if at most one leftover bit, else rx_error.
  task automatic run_pkt(input string tag, input logic [7:0] bytes[$], input int nextra, input bit jitter);
    build(bytes, nextra, jitter);
    clr();
    play();
    chk_bytes(tag, bytes);
    chk({tag, " eop"}, n_eop, (nextra <= 1) ? 1 : 0);
    chk({tag, " err"}, n_err, (nextra <= 1) ? 0 : 1);
    chk({tag, " valid+eop same cycle"}, n_both, 0);
    chk({tag, " valid while inactive"}, n_val_inact, 0);
    chk({tag, " active low after"}, {31'h0, rx_if.rx_active}, 0);
  endtask

  logic [7:0] pk[$];
  int idx7;

  initial begin
    // reset state
    repeat (3) @(negedge clk48);
    chk("reset rx_data",   {24'h0, rx_if.rx_data}, 0);
    chk("reset rx_valid",  {31'h0, rx_if.rx_valid}, 0);
    chk("reset rx_active", {31'h0, rx_if.rx_active}, 0);
    chk("reset rx_eop",    {31'h0, rx_if.rx_eop}, 0);
    chk("reset rx_error",  {31'h0, rx_if.rx_error}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk48);

    // single byte A5
    pk = '{8'hA5};
    run_pkt("A5", pk, 0, 1'b0);
    chk("A5 active rose before valid", {31'h0, (rise_cyc < valid_cyc)}, 1);
    chk("A5 active falls with eop", fall_cyc, eop_cyc);
    chk("A5 eop >= 2 bits after valid", {31'h0, (eop_cyc - valid_cyc >= 8)}, 1);

    // FF FF needs stuffed zeros
    pk = '{8'hFF, 8'hFF};
    run_pkt("FFFF", pk, 0, 1'b0);

    // seven ones with no stuffed zero
    start_pkt(1'b0);
    for (int i = 0; i < 7; i++) nrzi(1'b1);
    idx7 = cl.size() - 1;
    end_pkt();
    clr();
    play();
    chk("stuff err count", n_err, 1);
    chk("stuff err timing", err_cyc, cs[idx7] + 6);
    chk("stuff no valid", got.size(), 0);
    chk("stuff no eop", n_eop, 0);
    chk("stuff active falls with err", fall_cyc, err_cyc);

    // jittered edges
    pk = '{8'h3C};
    run_pkt("jitter 3C", pk, 0, 1'b1);

    // residual bits: 4 leftover -> error, 1 dribble -> eop
    pk = '{8'h12};
    run_pkt("12 +4 bits", pk, 4, 1'b0);
    pk = '{8'($urandom)};
    run_pkt("dribble 1", pk, 1, 1'b0);

    // random packets
    for (int p = 0; p < 6; p++) begin
      pk.delete();
      for (int b = 0; b < int'($urandom_range(3, 1)); b++) pk.push_back(8'($urandom));
      run_pkt("random", pk, int'($urandom_range(1)), 1'b0);
    end

    // reset in the middle of a byte while the line keeps toggling
    pk = '{8'hDB};
    build(pk, 0, 1'b0);
    clr();
    fork
      play();
      begin
        repeat (66) @(negedge clk48);
        chk("pre-reset active", {31'h0, rx_if.rx_active}, 1);
        rst_n = 1'b0;
        #1;
        chk("midpkt reset active", {31'h0, rx_if.rx_active}, 0);
        chk("midpkt reset data",   {24'h0, rx_if.rx_data}, 0);
        chk("midpkt reset valid",  {31'h0, rx_if.rx_valid}, 0);
        chk("midpkt reset eop",    {31'h0, rx_if.rx_eop}, 0);
        chk("midpkt reset error",  {31'h0, rx_if.rx_error}, 0);
        repeat (5) @(negedge clk48);
        rst_n = 1'b1;
      end
    join
    chk("post-reset no valid", got.size(), 0);
    chk("post-reset no eop", n_eop, 0);
    chk("post-reset no err", n_err, 0);
    pk = '{8'h5A};
    run_pkt("after reset 5A", pk, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
